// File: rtl/mul_hilo_ctrl.sv
// Issue/commit controller for the magnitude-array multiplier. It latches the operands,
// waits out the multiplier latency, fixes up the sign and commits the product to HI/LO.
module mul_hilo_ctrl #(
    parameter int MUL_LATENCY = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mul_req,
    input  logic        mul_sign,
    input  logic [31:0] mul_op1,
    input  logic [31:0] mul_op2,
    input  logic        flush,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] hilo_wdata,
    output logic        m_sign,
    output logic [31:0] m_op1,
    output logic [31:0] m_op2,
    input  logic [63:0] mul_result,
    output logic        stall,
    output logic        mul_done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int CW = $clog2(MUL_LATENCY + 1);
    localparam logic [CW-1:0] LAT = CW'(MUL_LATENCY);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          neg;
    logic [63:0]   prod;

    // The multiplier only sees magnitudes, so the product is negated when the signs differ.
    assign neg  = m_sign & (m_op1[31] ^ m_op2[31]);
    assign prod = neg ? (~mul_result + 64'd1) : mul_result;

    assign stall    = ((state != BUSY) & mul_req & ~flush) | ((state == BUSY) & ~flush);
    assign mul_done = (state == DONE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            cnt    <= '0;
            m_sign <= 1'b0;
            m_op1  <= '0;
            m_op2  <= '0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            case (state)
                BUSY: begin
                    if (flush) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt < LAT) begin
                        cnt <= cnt + CW'(1);
                    end else begin
                        hi    <= prod[63:32];
                        lo    <= prod[31:0];
                        state <= DONE;
                    end
                end
                default: begin
                    if (mul_req && !flush) begin
                        m_sign <= mul_sign;
                        m_op1  <= mul_op1;
                        m_op2  <= mul_op2;
                        cnt    <= '0;
                        state  <= BUSY;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
            // Direct MTHI/MTLO writes come last so they override a coinciding commit.
            if (hi_we) hi <= hilo_wdata;
            if (lo_we) lo <= hilo_wdata;
        end
    end

endmodule

// File: tb/tb_mul_hilo_ctrl.sv
// Self-checking bench: two controllers (latency 1 and 3) share one stimulus stream and
// are compared every cycle against a transaction-level reference model.
module tb_mul_hilo_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        mul_req, mul_sign, flush, hi_we, lo_we;
    logic [31:0] mul_op1, mul_op2, hilo_wdata;

    logic        m_sign_1, stall_1, mul_done_1;
    logic [31:0] m_op1_1, m_op2_1, hi_1, lo_1;
    logic [63:0] mul_result_1;
    logic        m_sign_3, stall_3, mul_done_3;
    logic [31:0] m_op1_3, m_op2_3, hi_3, lo_3;
    logic [63:0] mul_result_3;

    int checks = 0;
    int errors = 0;

    int          lat    [2] = '{1, 3};
    int          remain [2];
    bit          done   [2];
    bit          esign  [2];
    logic [31:0] eop1   [2];
    logic [31:0] eop2   [2];
    logic [31:0] ehi    [2];
    logic [31:0] elo    [2];
    logic [63:0] pend   [2];

    always #5 clk = ~clk;

    mul_hilo_ctrl #(.MUL_LATENCY(1)) dut1 (
        .clk(clk), .resetn(resetn), .mul_req(mul_req), .mul_sign(mul_sign),
        .mul_op1(mul_op1), .mul_op2(mul_op2), .flush(flush), .hi_we(hi_we),
        .lo_we(lo_we), .hilo_wdata(hilo_wdata), .m_sign(m_sign_1), .m_op1(m_op1_1),
        .m_op2(m_op2_1), .mul_result(mul_result_1), .stall(stall_1),
        .mul_done(mul_done_1), .hi(hi_1), .lo(lo_1)
    );

    mul_hilo_ctrl #(.MUL_LATENCY(3)) dut3 (
        .clk(clk), .resetn(resetn), .mul_req(mul_req), .mul_sign(mul_sign),
        .mul_op1(mul_op1), .mul_op2(mul_op2), .flush(flush), .hi_we(hi_we),
        .lo_we(lo_we), .hilo_wdata(hilo_wdata), .m_sign(m_sign_3), .m_op1(m_op1_3),
        .m_op2(m_op2_3), .mul_result(mul_result_3), .stall(stall_3),
        .mul_done(mul_done_3), .hi(hi_3), .lo(lo_3)
    );

    // Magnitude-array multiplier stand-in: unsigned product of the operand magnitudes.
    function automatic logic [63:0] magMul(input logic s, input logic [31:0] a,
                                           input logic [31:0] b);
        logic [31:0] ma, mb;
        ma = (s && a[31]) ? (32'd0 - a) : a;
        mb = (s && b[31]) ? (32'd0 - b) : b;
        return {32'd0, ma} * {32'd0, mb};
    endfunction

    always_comb mul_result_1 = magMul(m_sign_1, m_op1_1, m_op2_1);
    always_comb mul_result_3 = magMul(m_sign_3, m_op1_3, m_op2_3);

    // Architectural product: sign- or zero-extend to 64 bits and multiply modulo 2^64.
    function automatic logic [63:0] refProduct(input logic s, input logic [31:0] a,
                                               input logic [31:0] b);
        logic [63:0] ea, eb;
        ea = s ? {{32{a[31]}}, a} : {32'd0, a};
        eb = s ? {{32{b[31]}}, b} : {32'd0, b};
        return ea * eb;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: observed %h, expected %h", tag, $time,
                     observed, expected);
        end
    endtask

    task automatic modelReset();
        for (int k = 0; k < 2; k++) begin
            remain[k] = 0; done[k] = 0; esign[k] = 0;
            eop1[k] = '0; eop2[k] = '0; ehi[k] = '0; elo[k] = '0; pend[k] = '0;
        end
    endtask

    task automatic compareDut(input int k, input logic st, input logic dn, input logic sg,
                              input logic [31:0] o1, input logic [31:0] o2,
                              input logic [31:0] h, input logic [31:0] l);
        bit exp_stall;
        exp_stall = (remain[k] > 0) ? !flush : (mul_req && !flush);
        checkOutput($sformatf("L%0d_stall", lat[k]), st, exp_stall);
        checkOutput($sformatf("L%0d_mul_done", lat[k]), dn, done[k]);
        checkOutput($sformatf("L%0d_m_sign", lat[k]), sg, esign[k]);
        checkOutput($sformatf("L%0d_m_op1", lat[k]), o1, eop1[k]);
        checkOutput($sformatf("L%0d_m_op2", lat[k]), o2, eop2[k]);
        checkOutput($sformatf("L%0d_hi", lat[k]), h, ehi[k]);
        checkOutput($sformatf("L%0d_lo", lat[k]), l, elo[k]);
    endtask

    // Busy lasts L+1 cycles after acceptance; the product lands as it ends.
    task automatic modelStep(input int k);
        done[k] = 0;
        if (remain[k] > 0) begin
            if (flush) begin
                remain[k] = 0;
            end else if (remain[k] == 1) begin
                ehi[k] = pend[k][63:32];
                elo[k] = pend[k][31:0];
                done[k] = 1;
                remain[k] = 0;
            end else begin
                remain[k]--;
            end
        end else if (mul_req && !flush) begin
            esign[k] = mul_sign; eop1[k] = mul_op1; eop2[k] = mul_op2;
            pend[k] = refProduct(mul_sign, mul_op1, mul_op2);
            remain[k] = lat[k] + 1;
        end
        if (hi_we) ehi[k] = hilo_wdata;
        if (lo_we) elo[k] = hilo_wdata;
    endtask

    task automatic applyStimulus(input logic req, input logic sgn, input logic [31:0] a,
                                 input logic [31:0] b, input logic fl, input logic hwe,
                                 input logic lwe, input logic [31:0] wd);
        mul_req = req; mul_sign = sgn; mul_op1 = a; mul_op2 = b;
        flush = fl; hi_we = hwe; lo_we = lwe; hilo_wdata = wd;
        #1;
        compareDut(0, stall_1, mul_done_1, m_sign_1, m_op1_1, m_op2_1, hi_1, lo_1);
        compareDut(1, stall_3, mul_done_3, m_sign_3, m_op1_3, m_op2_3, hi_3, lo_3);
        modelStep(0);
        modelStep(1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 32'd0, 32'd0, 0, 0, 0, 32'd0);
    endtask

    function automatic logic [31:0] pickOperand();
        logic [31:0] corners [6];
        corners = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFE};
        if ($urandom_range(3) == 0) return corners[$urandom_range(5)];
        return $urandom;
    endfunction

    initial begin
        resetn = 1'b0;
        mul_req = 0; mul_sign = 0; mul_op1 = '0; mul_op2 = '0;
        flush = 0; hi_we = 0; lo_we = 0; hilo_wdata = '0;
        modelReset();
        #2;
        compareDut(0, stall_1, mul_done_1, m_sign_1, m_op1_1, m_op2_1, hi_1, lo_1);
        compareDut(1, stall_3, mul_done_3, m_sign_3, m_op1_3, m_op2_3, hi_3, lo_3);
        #10 resetn = 1'b1;
        @(posedge clk);
        #1;

        applyStimulus(1, 0, 32'd7, 32'd6, 0, 0, 0, 32'd0);
        idle(2);
        checkOutput("case1_done_L1", mul_done_1, 1'b1);
        checkOutput("case1_lo_L1", lo_1, 64'h2A);
        idle(2);
        checkOutput("case1_done_L3", mul_done_3, 1'b1);
        checkOutput("case1_lo_L3", lo_3, 64'h2A);
        idle(1);

        applyStimulus(1, 1, 32'hFFFFFFFD, 32'd5, 0, 0, 0, 32'd0);
        idle(4);
        checkOutput("case2_hi_L3", hi_3, 64'hFFFFFFFF);
        checkOutput("case2_lo_L3", lo_3, 64'hFFFFFFF1);
        applyStimulus(1, 1, 32'hFFFFFFFC, 32'hFFFFFFFC, 0, 0, 0, 32'd0);
        idle(4);
        checkOutput("case2b_lo_L3", lo_3, 64'h10);

        applyStimulus(1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 32'd0);
        applyStimulus(0, 1, 32'h12345678, 32'h9, 0, 0, 0, 32'd0);
        idle(3);
        checkOutput("case3_hi_L3", hi_3, 64'hFFFFFFFE);
        checkOutput("case3_lo_L3", lo_3, 64'h1);

        applyStimulus(0, 0, 32'd0, 32'd0, 0, 1, 1, 32'h11);
        applyStimulus(1, 0, 32'd9, 32'd9, 0, 0, 0, 32'd0);
        applyStimulus(0, 0, 32'd0, 32'd0, 0, 0, 0, 32'd0);
        applyStimulus(0, 0, 32'd0, 32'd0, 1, 0, 0, 32'd0);
        checkOutput("case4_stall_L3", stall_3, 1'b0);
        idle(5);
        checkOutput("case4_hi_L3", hi_3, 64'h11);
        applyStimulus(1, 1, 32'd5, 32'd5, 1, 0, 0, 32'd0);

        applyStimulus(1, 0, 32'd2, 32'd3, 0, 0, 0, 32'd0);
        applyStimulus(0, 0, 32'd0, 32'd0, 0, 0, 0, 32'd0);
        applyStimulus(0, 0, 32'd0, 32'd0, 0, 0, 1, 32'hABCD);
        checkOutput("case5_lo_L1", lo_1, 64'hABCD);
        checkOutput("case5_hi_L1", hi_1, 64'h0);
        applyStimulus(1, 0, 32'd4, 32'd4, 0, 0, 0, 32'd0);
        idle(2);
        checkOutput("case5_b2b_done_L1", mul_done_1, 1'b1);
        idle(3);

        applyStimulus(1, 0, 32'd100, 32'd100, 0, 0, 0, 32'd0);
        applyStimulus(0, 0, 32'd0, 32'd0, 0, 0, 0, 32'd0);
        resetn = 1'b0;
        #1;
        modelReset();
        compareDut(0, stall_1, mul_done_1, m_sign_1, m_op1_1, m_op2_1, hi_1, lo_1);
        compareDut(1, stall_3, mul_done_3, m_sign_3, m_op1_3, m_op2_3, hi_3, lo_3);
        #4 resetn = 1'b1;
        @(posedge clk);
        #1;
        idle(6);

        for (int i = 0; i < 600; i++) begin
            applyStimulus($urandom_range(1), $urandom_range(1), pickOperand(), pickOperand(),
                          $urandom_range(11) == 0, $urandom_range(9) == 0,
                          $urandom_range(9) == 0, $urandom);
        end
        idle(6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
